// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU request scheduler.
package alu_sched_pkg;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    AND = 3'd2,
    OR  = 3'd3,
    XOR = 3'd4,
    SHL = 3'd5,
    SHR = 3'd6,
    MUL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } sched_state_e;

  typedef enum logic {
    HOST  = 1'b0,
    PANEL = 1'b1
  } req_e;

  // Pending front-panel request: opcode plus 2-bit DIP operands.
  typedef struct packed {
    alu_op_e    op;
    logic [1:0] a;
    logic [1:0] b;
  } panel_req_t;

  localparam logic [2:0] ADDR_OPA    = 3'd0;
  localparam logic [2:0] ADDR_OPB    = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_RESULT = 3'd4;
  localparam logic [2:0] ADDR_CYCLES = 3'd5;

  localparam int unsigned CTRL_GO_BIT = 8;

  localparam int unsigned ST_BUSY  = 0;
  localparam int unsigned ST_DONE  = 1;
  localparam int unsigned ST_ERR   = 2;
  localparam int unsigned ST_OVR   = 3;
  localparam int unsigned ST_PANEL = 4;

endpackage

// File: rtl/btn_press_detect.sv
// Synchronizes raw active-low buttons and flags one-cycle presses (falling edges).
module btn_press_detect #(
  parameter int unsigned N_BTN       = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] press_c
);

  logic [N_BTN-1:0] sync_q [SYNC_STAGES];
  logic [N_BTN-1:0] prev_q;

  // Synchronizer chain followed by one history stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= btn_n;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press_c = prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one multi-cycle ALU between the HPS Avalon-MM slave and the front panel.
module alu_req_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        avs_address,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_read,
  output logic [31:0]       avs_readdata,
  input  logic [1:0]        btn_n,
  input  logic [3:0]        dipsw,
  output logic [7:0]        leds,
  output logic              alu_start,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_e      state_q, state_d;
  req_e              owner_q, owner_d;
  req_e              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
  alu_op_e           ctrl_op_q, ctrl_op_d;
  logic              host_pending_q, host_pending_d;
  logic              host_busy_q, host_busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              overrun_q, overrun_d;
  logic              panel_pending_q, panel_pending_d;
  panel_req_t        panel_req_q, panel_req_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [15:0]       cycles_q, cycles_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        leds_q, leds_d;
  logic              alu_start_q, alu_start_d;
  alu_op_e           alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [31:0]       readdata_q, readdata_d;

  logic [1:0]        press_c;
  logic [31:0]       status_c;
  logic [31:0]       rd_mux_c;
  logic [31:0]       latency_c;
  logic              host_go_c;
  logic              panel_busy_c;
  logic              grant_host_c;

  btn_press_detect #(
    .N_BTN       (2),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_n   (btn_n),
    .press_c (press_c)
  );

  // Read-back mux over the pre-edge register state.
  always_comb begin
    status_c           = '0;
    status_c[ST_BUSY]  = host_busy_q;
    status_c[ST_DONE]  = done_q;
    status_c[ST_ERR]   = err_q;
    status_c[ST_OVR]   = overrun_q;
    status_c[ST_PANEL] = panel_pending_q;
    case (avs_address)
      ADDR_OPA:    rd_mux_c = 32'(opa_q);
      ADDR_OPB:    rd_mux_c = 32'(opb_q);
      ADDR_CTRL:   rd_mux_c = 32'(ctrl_op_q);
      ADDR_STATUS: rd_mux_c = status_c;
      ADDR_RESULT: rd_mux_c = 32'(result_q);
      ADDR_CYCLES: rd_mux_c = 32'(cycles_q);
      default:     rd_mux_c = '0;
    endcase
  end

  // Next-state logic: bus writes, request capture, arbitration and ALU sequencing.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    last_grant_d    = last_grant_q;
    opa_d           = opa_q;
    opb_d           = opb_q;
    ctrl_op_d       = ctrl_op_q;
    host_pending_d  = host_pending_q;
    host_busy_d     = host_busy_q;
    done_d          = done_q;
    err_d           = err_q;
    overrun_d       = overrun_q;
    panel_pending_d = panel_pending_q;
    panel_req_d     = panel_req_q;
    result_d        = result_q;
    cycles_d        = cycles_q;
    cnt_d           = cnt_q;
    leds_d          = leds_q;
    alu_start_d     = 1'b0;
    alu_op_d        = alu_op_q;
    alu_a_d         = alu_a_q;
    alu_b_d         = alu_b_q;
    readdata_d      = readdata_q;
    latency_c       = 32'(cnt_q) + 32'd1;

    if (avs_read) readdata_d = rd_mux_c;

    if (avs_write) begin
      case (avs_address)
        ADDR_OPA:  opa_d = DATA_W'(avs_writedata);
        ADDR_OPB:  opb_d = DATA_W'(avs_writedata);
        ADDR_CTRL: if (!host_busy_q) ctrl_op_d = alu_op_e'(avs_writedata[2:0]);
        ADDR_STATUS: begin
          if (avs_writedata[ST_DONE]) done_d    = 1'b0;
          if (avs_writedata[ST_ERR])  err_d     = 1'b0;
          if (avs_writedata[ST_OVR])  overrun_d = 1'b0;
        end
        default: ;
      endcase
    end

    // Host GO is judged against registered busy, so GO on the completion cycle overruns.
    host_go_c = avs_write && (avs_address == ADDR_CTRL) && avs_writedata[CTRL_GO_BIT];
    if (host_go_c) begin
      if (host_busy_q) begin
        overrun_d = 1'b1;
      end else begin
        host_pending_d = 1'b1;
        host_busy_d    = 1'b1;
        done_d         = 1'b0;
      end
    end

    // One outstanding panel request at a time; btn0 (ADD) beats btn1 (SUB).
    panel_busy_c = panel_pending_q || ((state_q != IDLE) && (owner_q == PANEL));
    if (!panel_busy_c && (|press_c)) begin
      panel_pending_d = 1'b1;
      panel_req_d.op  = press_c[0] ? ADD : SUB;
      panel_req_d.a   = dipsw[3:2];
      panel_req_d.b   = dipsw[1:0];
    end

    grant_host_c = host_pending_q && (!panel_pending_q || (last_grant_q == PANEL));

    case (state_q)
      IDLE: begin
        if (host_pending_q || panel_pending_q) begin
          if (grant_host_c) begin
            owner_d        = HOST;
            last_grant_d   = HOST;
            alu_op_d       = ctrl_op_q;
            alu_a_d        = opa_q;
            alu_b_d        = opb_q;
            host_pending_d = 1'b0;
          end else begin
            owner_d         = PANEL;
            last_grant_d    = PANEL;
            alu_op_d        = panel_req_q.op;
            alu_a_d         = DATA_W'(panel_req_q.a);
            alu_b_d         = DATA_W'(panel_req_q.b);
            panel_pending_d = 1'b0;
          end
          alu_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (alu_done) begin
          if (owner_q == HOST) begin
            result_d    = alu_result;
            done_d      = 1'b1;
            host_busy_d = 1'b0;
          end else begin
            leds_d = alu_result[7:0];
          end
          cycles_d = (latency_c > 32'h0000_FFFF) ? 16'hFFFF : latency_c[15:0];
          state_d  = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d = 1'b1;
          if (owner_q == HOST) begin
            result_d    = '0;
            host_busy_d = 1'b0;
          end else begin
            leds_d = 8'hFF;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset clears everything, host wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      owner_q         <= HOST;
      last_grant_q    <= PANEL;
      opa_q           <= '0;
      opb_q           <= '0;
      ctrl_op_q       <= ADD;
      host_pending_q  <= 1'b0;
      host_busy_q     <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      overrun_q       <= 1'b0;
      panel_pending_q <= 1'b0;
      panel_req_q     <= '0;
      result_q        <= '0;
      cycles_q        <= '0;
      cnt_q           <= '0;
      leds_q          <= '0;
      alu_start_q     <= 1'b0;
      alu_op_q        <= ADD;
      alu_a_q         <= '0;
      alu_b_q         <= '0;
      readdata_q      <= '0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      last_grant_q    <= last_grant_d;
      opa_q           <= opa_d;
      opb_q           <= opb_d;
      ctrl_op_q       <= ctrl_op_d;
      host_pending_q  <= host_pending_d;
      host_busy_q     <= host_busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      overrun_q       <= overrun_d;
      panel_pending_q <= panel_pending_d;
      panel_req_q     <= panel_req_d;
      result_q        <= result_d;
      cycles_q        <= cycles_d;
      cnt_q           <= cnt_d;
      leds_q          <= leds_d;
      alu_start_q     <= alu_start_d;
      alu_op_q        <= alu_op_d;
      alu_a_q         <= alu_a_d;
      alu_b_q         <= alu_b_d;
      readdata_q      <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign leds         = leds_q;
  assign alu_start    = alu_start_q;
  assign alu_op       = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Scoreboard bench for alu_req_scheduler with a behavioural ALU of programmable latency.
module tb_alu_req_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [1:0]  btn_n;
  logic [3:0]  dipsw;
  logic [7:0]  leds;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_done;

  int total = 0;
  int bad   = 0;

  // ALU model state, owned by the main thread through tick().
  int          alu_lat   = 3;
  bit          alu_hang  = 1'b0;
  int          alu_cd    = 0;
  logic [31:0] alu_res_nx;
  int          done_cnt  = 0;
  int          start_cnt = 0;
  logic [31:0] last_a, last_b;
  logic [2:0]  last_op;
  logic [31:0] start_log [$];

  logic [31:0] exp_res_q [$];
  logic [7:0]  exp_led_q [$];

  alu_req_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .avs_address   (avs_address),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .btn_n         (btn_n),
    .dipsw         (dipsw),
    .leds          (leds),
    .alu_start     (alu_start),
    .alu_op        (alu_op),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_result    (alu_result),
    .alu_done      (alu_done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a << b[4:0];
      3'd6:    return a >> b[4:0];
      default: return a * b;
    endcase
  endfunction

  // Advance one cycle, sample #1 after the edge, and run the ALU model.
  task automatic tick();
    @(posedge clk);
    #1;
    alu_done = 1'b0;
    if (alu_cd > 0) begin
      alu_cd--;
      if (alu_cd == 0) begin
        alu_done   = 1'b1;
        alu_result = alu_res_nx;
        done_cnt++;
      end
    end
    if (alu_start) begin
      start_cnt++;
      start_log.push_back(alu_a);
      last_a  = alu_a;
      last_b  = alu_b;
      last_op = alu_op;
      if (!alu_hang) begin
        alu_cd     = alu_lat;
        alu_res_nx = alu_fn(alu_op, alu_a, alu_b);
      end
    end
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    avs_address = addr;
    avs_read    = 1'b1;
    tick();
    data        = avs_readdata;
    avs_read    = 1'b0;
  endtask

  task automatic wait_dones(input int n, input int budget, input string nm);
    int target = done_cnt + n;
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    total++;
    if (done_cnt < target) begin
      bad++;
      $display("FAIL %s: alu_done count %0d, required %0d within %0d cycles", nm, done_cnt, target, budget);
    end
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alu_cd = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    total++; if (avs_readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata: got %h want 0", avs_readdata); end
    total++; if (leds !== 8'h00) begin bad++; $display("FAIL reset_leds: got %h want 00", leds); end
    total++; if ({alu_start, alu_op, alu_a, alu_b} !== '0) begin bad++; $display("FAIL reset_alu_if: start=%b op=%0d a=%h b=%h want all 0", alu_start, alu_op, alu_a, alu_b); end
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 0", rd); end
    bus_read(3'd4, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 0", rd); end
    bus_read(3'd5, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_cycles: got %h want 0", rd); end
  endtask

  task automatic test_host_op();
    logic [31:0] rd, e;
    int s0 = start_cnt;
    alu_lat = 3;
    bus_write(3'd0, 32'd7);
    bus_write(3'd1, 32'd5);
    bus_write(3'd2, 32'h100);
    exp_res_q.push_back(32'd12);
    wait_dones(1, 50, "host_done");
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL host_start_pulses: got %0d want 1", start_cnt - s0); end
    total++; if ({last_op, last_a, last_b} !== {3'd0, 32'd7, 32'd5}) begin bad++; $display("FAIL host_operands: op=%0d a=%0d b=%0d want 0 7 5", last_op, last_a, last_b); end
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h2) begin bad++; $display("FAIL host_status: got %h want 2", rd); end
    bus_read(3'd4, rd);
    e = exp_res_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL host_result: got %0d want %0d", rd, e); end
    bus_read(3'd5, rd);
    total++; if (rd !== 32'd3) begin bad++; $display("FAIL host_cycles: got %0d want 3", rd); end
  endtask

  task automatic test_panel_op();
    logic [31:0] rd;
    logic [7:0]  e;
    int s0 = start_cnt;
    dipsw = 4'b1110;
    exp_led_q.push_back(8'h01);
    btn_n = 2'b01;
    repeat (3) tick();
    btn_n = 2'b11;
    wait_dones(1, 50, "panel_done");
    total++; if (start_cnt - s0 !== 1) begin bad++; $display("FAIL panel_start_pulses: got %0d want 1", start_cnt - s0); end
    total++; if ({last_op, last_a, last_b} !== {3'd1, 32'd3, 32'd2}) begin bad++; $display("FAIL panel_operands: op=%0d a=%0d b=%0d want 1 3 2", last_op, last_a, last_b); end
    e = exp_led_q.pop_front();
    total++; if (leds !== e) begin bad++; $display("FAIL panel_leds_sub: got %h want %h", leds, e); end
    bus_read(3'd3, rd);
    total++; if (rd[4] !== 1'b0) begin bad++; $display("FAIL panel_pending_clear: got %b want 0", rd[4]); end
    // Both buttons together: btn0 (ADD) must win, 1+1=2 rather than 0.
    dipsw = 4'b0101;
    exp_led_q.push_back(8'h02);
    btn_n = 2'b00;
    repeat (3) tick();
    btn_n = 2'b11;
    wait_dones(1, 50, "panel_both_done");
    e = exp_led_q.pop_front();
    total++; if (leds !== e) begin bad++; $display("FAIL panel_both_btn: got %h want %h", leds, e); end
  endtask

  task automatic test_contention();
    logic [31:0] rd, e;
    logic [7:0]  el;
    do_reset();
    // Tie after reset: press reaches the scheduler in the same cycle as GO; host first.
    start_log.delete();
    dipsw = 4'b0111;
    bus_write(3'd0, 32'd100);
    bus_write(3'd1, 32'd1);
    btn_n = 2'b10;
    tick();
    tick();
    bus_write(3'd2, 32'h100);
    exp_res_q.push_back(32'd101);
    exp_led_q.push_back(8'd4);
    btn_n = 2'b11;
    wait_dones(2, 100, "tie1_done");
    total++; if (start_log.size() != 2 || start_log[0] !== 32'd100 || start_log[1] !== 32'd1) begin
      bad++; $display("FAIL tie1_order: grants=%0d first_a=%0d want 2 grants, host(a=100) then panel(a=1)", start_log.size(), (start_log.size() > 0) ? start_log[0] : 0);
    end
    bus_read(3'd4, rd);
    e = exp_res_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL tie1_result: got %0d want %0d", rd, e); end
    el = exp_led_q.pop_front();
    total++; if (leds !== el) begin bad++; $display("FAIL tie1_leds: got %h want %h", leds, el); end
    // Host-only op so the host holds last grant, then a second tie: panel first.
    bus_write(3'd0, 32'd20);
    bus_write(3'd1, 32'd22);
    bus_write(3'd2, 32'h100);
    exp_res_q.push_back(32'd42);
    wait_dones(1, 50, "host_only_done");
    bus_read(3'd4, rd);
    e = exp_res_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL host_only_result: got %0d want %0d", rd, e); end
    start_log.delete();
    dipsw = 4'b1011;
    bus_write(3'd0, 32'd50);
    bus_write(3'd1, 32'd50);
    btn_n = 2'b10;
    tick();
    tick();
    bus_write(3'd2, 32'h100);
    exp_res_q.push_back(32'd100);
    exp_led_q.push_back(8'd5);
    btn_n = 2'b11;
    wait_dones(2, 100, "tie2_done");
    total++; if (start_log.size() != 2 || start_log[0] !== 32'd2 || start_log[1] !== 32'd50) begin
      bad++; $display("FAIL tie2_order: grants=%0d first_a=%0d want 2 grants, panel(a=2) then host(a=50)", start_log.size(), (start_log.size() > 0) ? start_log[0] : 0);
    end
    bus_read(3'd4, rd);
    e = exp_res_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL tie2_result: got %0d want %0d", rd, e); end
    el = exp_led_q.pop_front();
    total++; if (leds !== el) begin bad++; $display("FAIL tie2_leds: got %h want %h", leds, el); end
  endtask

  task automatic test_overrun();
    logic [31:0] rd, e;
    int s0 = start_cnt;
    alu_lat = 5;
    bus_write(3'd0, 32'd3);
    bus_write(3'd1, 32'd4);
    bus_write(3'd2, 32'h100);
    exp_res_q.push_back(32'd7);
    bus_write(3'd2, 32'h101);
    wait_dones(1, 50, "overrun_done");
    total++; if (start_cnt - s0 !== 1 || last_op !== 3'd0) begin bad++; $display("FAIL overrun_single_op: starts=%0d op=%0d want 1 start op 0", start_cnt - s0, last_op); end
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h0A) begin bad++; $display("FAIL overrun_status: got %h want 0a", rd); end
    bus_read(3'd4, rd);
    e = exp_res_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL overrun_result: got %0d want %0d", rd, e); end
    bus_write(3'd3, 32'h8);
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h02) begin bad++; $display("FAIL overrun_w1c: got %h want 02", rd); end
  endtask

  task automatic test_timeout();
    logic [31:0] rd, e;
    // ALU never answers.
    alu_hang = 1'b1;
    bus_write(3'd0, 32'd11);
    bus_write(3'd2, 32'h100);
    exp_res_q.push_back(32'd0);
    repeat (1000) tick();
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h01) begin bad++; $display("FAIL timeout_still_busy: got %h want 01", rd); end
    repeat (40) tick();
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h04) begin bad++; $display("FAIL timeout_status: got %h want 04", rd); end
    bus_read(3'd4, rd);
    e = exp_res_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL timeout_result: got %h want %h", rd, e); end
    alu_result = 32'hDEAD;
    alu_done   = 1'b1;
    tick();
    bus_read(3'd4, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL late_done_ignored: result %h want 0", rd); end
    alu_hang = 1'b0;
    bus_write(3'd3, 32'h4);
    // Recovery: next GO runs normally.
    alu_lat = 3;
    bus_write(3'd0, 32'd9);
    bus_write(3'd1, 32'd4);
    bus_write(3'd2, 32'h101);
    exp_res_q.push_back(32'd5);
    wait_dones(1, 50, "recover_done");
    bus_read(3'd4, rd);
    e = exp_res_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL recover_result: got %0d want %0d", rd, e); end
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h02) begin bad++; $display("FAIL recover_status: got %h want 02", rd); end
    // Done in the last allowed WAIT cycle is a success.
    alu_lat = 1024;
    bus_write(3'd2, 32'h100);
    exp_res_q.push_back(32'd13);
    wait_dones(1, 1100, "edge_done");
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h02) begin bad++; $display("FAIL edge_status: got %h want 02", rd); end
    bus_read(3'd4, rd);
    e = exp_res_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL edge_result: got %0d want %0d", rd, e); end
    bus_read(3'd5, rd);
    total++; if (rd !== 32'd1024) begin bad++; $display("FAIL edge_cycles: got %0d want 1024", rd); end
    // One cycle later is a timeout, and the late done is ignored.
    alu_lat = 1025;
    bus_write(3'd2, 32'h100);
    exp_res_q.push_back(32'd0);
    repeat (1100) tick();
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h04) begin bad++; $display("FAIL edge_plus1_status: got %h want 04", rd); end
    bus_read(3'd4, rd);
    e = exp_res_q.pop_front();
    total++; if (rd !== e) begin bad++; $display("FAIL edge_plus1_result: got %h want %h", rd, e); end
    alu_lat = 3;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int s0;
    alu_lat = 10;
    bus_write(3'd2, 32'h100);
    repeat (4) tick();
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h05) begin bad++; $display("FAIL mid_status_before: got %h want 05", rd); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if ({leds, alu_start, alu_op, alu_a} !== '0) begin bad++; $display("FAIL mid_reset_outputs: leds=%h start=%b op=%0d a=%h want all 0", leds, alu_start, alu_op, alu_a); end
    s0 = start_cnt;
    repeat (15) tick();
    total++; if (start_cnt !== s0) begin bad++; $display("FAIL mid_no_restart: starts %0d want %0d", start_cnt, s0); end
    bus_read(3'd3, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_status_after: got %h want 0", rd); end
    bus_read(3'd4, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_stale_done: result %h want 0", rd); end
    bus_read(3'd5, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL mid_cycles: got %h want 0", rd); end
  endtask

  initial begin
    reset         = 1'b1;
    avs_address   = 3'd0;
    avs_write     = 1'b0;
    avs_writedata = 32'h0;
    avs_read      = 1'b0;
    btn_n         = 2'b11;
    dipsw         = 4'b0000;
    alu_result    = 32'h0;
    alu_done      = 1'b0;
    test_reset();
    test_host_op();
    test_panel_op();
    test_contention();
    test_overrun();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_req_scheduler.md
Name: alu_req_scheduler

Overview:
- Shares one multi-cycle ALU between two requesters: the HPS lightweight-bridge Avalon-MM slave, and the front panel (buttons plus DIP switches).
- Arbitrates round-robin between them, sequences the ALU start/done handshake, and enforces a timeout.
- Returns host results through registers and shows panel results on the 8 LEDs.
- Sits in the FPGA fabric between the HPS bridge, the board I/O and the ALU core.

Parameters:
- DATA_W, 32, operand/result width.
- TIMEOUT_CYCLES, 1024, maximum cycles in WAIT before abort.
- SYNC_STAGES, 2, button synchronizer depth.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- avs_address  in  3  word address.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  32  read data, fixed latency 1.
- btn_n  in  2  raw push-buttons, active-low, asynchronous.
- dipsw  in  4  raw DIP switches.
- leds  out  8  panel result display.
- alu_start  out  1  one-cycle start pulse.
- alu_op  out  3  opcode, held from ISSUE until done.
- alu_a  out  DATA_W  operand A, held.
- alu_b  out  DATA_W  operand B, held.
- alu_result  in  DATA_W  valid when alu_done=1.
- alu_done  in  1  one-cycle completion pulse.

Behaviour:
- Reset values:
  - Outputs: avs_readdata=0, leds=0, alu_start=0, alu_op=0, alu_a=0, alu_b=0.
  - All registers 0. last_grant=PANEL, so the host wins the first tie.
- Register map (word addresses):
  - 0 OPA: RW.
  - 1 OPB: RW.
  - 2 CTRL: write bits[2:0]=op, bit8=GO. Reads {bits[2:0] last op}.
  - 3 STATUS: bit0 host_busy; bit1 done (sticky, W1C); bit2 err_timeout (sticky, W1C); bit3 overrun (sticky, W1C); bit4 panel_pending.
  - 4 RESULT: RO.
  - 5 CYCLES: RO, latency of the last completed op, 16-bit saturating.
  - 6–7: read 0, writes ignored.
- Reads: readdata is registered from the pre-edge register state. It updates only when avs_read=1 and otherwise holds its value.
- Host request:
  - Write CTRL with GO=1 while host_busy=0 sets host_pending and host_busy, and clears done.
  - GO while host_busy=1 is ignored and sets overrun. Busy is evaluated on the registered state, so a GO in the same cycle as completion is still an overrun.
- Panel request:
  - Each btn_n bit passes through SYNC_STAGES flops, then press (falling-edge) detection.
  - Press on btn0 requests ADD; press on btn1 requests SUB. Operands: a={30'b0,dipsw[3:2]}, b={30'b0,dipsw[1:0]}, sampled at the press cycle.
  - Press while panel_pending or panel in flight is dropped.
  - Simultaneous btn0 and btn1 presses: btn0 wins.
- FSM:
  - IDLE: if one requester is pending, grant it. If both are pending, grant the one != last_grant. On grant, latch operands and op into alu_a/alu_b/alu_op, update last_grant, clear that requester's pending flag, and go to ISSUE.
  - ISSUE: alu_start=1 for exactly 1 cycle, clear the cycle counter, go to WAIT.
  - WAIT: count cycles.
    - On alu_done: capture alu_result to the owner's destination (host → RESULT, set done, clear host_busy; panel → leds=result[7:0]). Write CYCLES, go to IDLE.
    - If the count reaches TIMEOUT_CYCLES without alu_done: set err_timeout. Host owner → RESULT=0, clear host_busy. Panel owner → leds=8'hFF. Go to IDLE.
  - Grant-to-start latency is 1 cycle (IDLE→ISSUE). The next grant is possible in the cycle after completion.
- Boundaries:
  - alu_done outside WAIT is ignored (late done after a timeout).
  - alu_done in the final timeout cycle counts as success.
  - Writes to OPA/OPB during WAIT do not disturb the in-flight op, because the held alu_a/alu_b registers are separate.
  - Reset mid-operation returns to IDLE and clears all state immediately. The ALU sees alu_start=0.

Decomposition:
- alu_sched_pkg holds:
  - opcode enum (ADD=0, SUB=1, AND, OR, XOR, SHL, SHR, MUL);
  - register address constants and STATUS bit indices;
  - FSM state enum {IDLE, ISSUE, WAIT};
  - requester enum {HOST, PANEL}.
- One sub-module, btn_press_detect: synchronizer plus falling-edge detector, per button bit, parameterized by SYNC_STAGES.

Test Plan:
- Host op: OPA=7, OPB=5, CTRL=GO|ADD; ALU model finishes after 3 cycles with 12 → alu_start pulses once, STATUS.done=1, RESULT=12, CYCLES=3.
- Panel op: dipsw=4'b1110, btn1 press (SUB) → alu_a=3, alu_b=2, op=1; ALU returns 1 → leds=8'h01.
- Contention: host GO and btn0 press in the same cycle after reset → host granted first, panel second. Repeat with both pending → grants alternate.
- Overrun: GO, then a second GO while busy → second ignored, STATUS.overrun=1; write 0x8 to STATUS → overrun=0.
- Timeout: ALU never asserts done → after 1024 WAIT cycles err_timeout=1, RESULT=0, host_busy=0. A later alu_done is ignored, and the next GO works normally.
- Reset during WAIT → next cycle: FSM IDLE, leds=0, STATUS=0, alu_start=0. A stale alu_done after reset causes no capture.
